// File: rtl/multicycle_ctrl_if.sv
// Bus between the multicycle controller and its datapath/testbench.
// The controller sees the instruction register and memory ready flags and
// drives the control word plus its status outputs.
interface multicycle_ctrl_if #(
    parameter int unsigned IW = 32
);
    logic [IW-1:0] irout;
    logic          imem_ready;
    logic          dmem_ready;
    logic [23:0]   ctrl;
    logic [2:0]    state_o;
    logic          halted;
    logic          error;

    // Datapath / stimulus side
    modport master (
        output irout, imem_ready, dmem_ready,
        input  ctrl, state_o, halted, error
    );

    // Controller side
    modport slave (
        input  irout, imem_ready, dmem_ready,
        output ctrl, state_o, halted, error
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle processor controller: sequences IF/ID/EX/MEM/WB, decodes the
// 24-bit control word from state and the instruction register, and traps
// to ERR on illegal opcodes or memory that stays not-ready too long.
module multicycle_ctrl #(
    parameter int unsigned   IW        = 32,
    parameter logic [IW-1:0] HALT_WORD = '1,
    parameter int unsigned   TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             reset,
    multicycle_ctrl_if.slave io_bus
);
    localparam int unsigned   CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] WaitLast = CW'(TIMEOUT - 1);

    // Control word bit positions, MSB first
    localparam int unsigned CReadim    = 23;
    localparam int unsigned CLdir      = 22;
    localparam int unsigned CLdnpc     = 21;
    localparam int unsigned CLdA       = 20;
    localparam int unsigned CLdB       = 19;
    localparam int unsigned CLdimm     = 18;
    localparam int unsigned COpcond    = 16;
    localparam int unsigned CAlusel1   = 15;
    localparam int unsigned CAlusel2   = 14;
    localparam int unsigned CAluen     = 13;
    localparam int unsigned CLdaluout  = 12;
    localparam int unsigned CAlufunc   = 8;
    localparam int unsigned CSeldest   = 7;
    localparam int unsigned CRegwrite  = 6;
    localparam int unsigned CWritedmem = 5;
    localparam int unsigned CReaddmem  = 4;
    localparam int unsigned CLdlmd     = 3;
    localparam int unsigned CSelwb     = 2;
    localparam int unsigned CBranch    = 1;
    localparam int unsigned CLdpc      = 0;

    typedef enum logic [2:0] {
        StIf  = 3'd0,
        StId  = 3'd1,
        StEx  = 3'd2,
        StMem = 3'd3,
        StWb  = 3'd4,
        StHlt = 3'd5,
        StErr = 3'd6
    } state_e;

    state_e        r_state;
    logic [CW-1:0] r_wait;
    logic          r_halted;
    logic          r_error;

    logic [5:0]  w_op6;
    logic [5:0]  w_func;
    logic [5:0]  w_rr_func;
    logic [5:0]  w_ri_func;
    logic        w_is_rr;
    logic        w_is_ri;
    logic        w_is_ld;
    logic        w_is_st;
    logic        w_is_br;
    logic        w_legal;
    logic        w_is_halt;
    logic        w_ready;
    logic [23:0] w_ctrl;

    assign w_op6     = io_bus.irout[IW-1 -: 6];
    assign w_func    = io_bus.irout[5:0];
    assign w_rr_func = w_func - 6'd1;
    assign w_ri_func = w_op6 - 6'h10;
    assign w_is_rr   = (w_op6[5:4] == 2'b00) && (w_func >= 6'd1) && (w_func <= 6'd10);
    assign w_is_ri   = (w_op6 >= 6'h10) && (w_op6 <= 6'h1A);
    assign w_is_ld   = (w_op6 == 6'h21);
    assign w_is_st   = (w_op6 == 6'h22);
    assign w_is_br   = (w_op6 >= 6'h30) && (w_op6 <= 6'h33);
    assign w_legal   = w_is_rr || w_is_ri || w_is_ld || w_is_st || w_is_br;
    assign w_is_halt = (io_bus.irout == HALT_WORD);
    // IF waits on instruction memory, MEM on data memory
    assign w_ready   = (r_state == StMem) ? io_bus.dmem_ready : io_bus.imem_ready;

    // State sequencing, wait counter and registered status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIf;
            r_wait   <= '0;
            r_halted <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                StIf, StMem: begin
                    // Ready beats the timeout when both happen in the same cycle
                    if (w_ready) begin
                        r_state <= (r_state == StIf) ? StId : StWb;
                        r_wait  <= '0;
                    end else if (r_wait == WaitLast) begin
                        r_state <= StErr;
                        r_error <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                StId: begin
                    if (w_is_halt) begin
                        r_state  <= StHlt;
                        r_halted <= 1'b1;
                    end else if (!w_legal) begin
                        r_state <= StErr;
                        r_error <= 1'b1;
                    end else begin
                        r_state <= StEx;
                    end
                end
                StEx: begin
                    r_state <= (w_is_ld || w_is_st) ? StMem : StWb;
                    r_wait  <= '0;
                end
                StWb: begin
                    r_state <= StIf;
                    r_wait  <= '0;
                end
                default: ; // HLT and ERR hold until reset
            endcase
        end
    end

    // Control word decode from current state and instruction
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            StIf: begin
                w_ctrl[CReadim] = 1'b1;
                if (io_bus.imem_ready) begin
                    w_ctrl[CLdir]  = 1'b1;
                    w_ctrl[CLdnpc] = 1'b1;
                end
            end
            StId: begin
                w_ctrl[CLdA]   = 1'b1;
                w_ctrl[CLdB]   = 1'b1;
                w_ctrl[CLdimm] = 1'b1;
            end
            StEx: begin
                w_ctrl[CAluen]    = 1'b1;
                w_ctrl[CLdaluout] = 1'b1;
                if (w_is_br) begin
                    w_ctrl[CAlusel2]       = 1'b1;
                    w_ctrl[CAlufunc +: 4]  = 4'b1010;
                    case (w_op6[1:0])
                        2'd0:    w_ctrl[COpcond +: 2] = 2'b11; // BR
                        2'd1:    w_ctrl[COpcond +: 2] = 2'b01; // BMI
                        2'd2:    w_ctrl[COpcond +: 2] = 2'b00; // BPL
                        default: w_ctrl[COpcond +: 2] = 2'b10; // BZ
                    endcase
                end else begin
                    w_ctrl[COpcond +: 2] = 2'b11;
                    w_ctrl[CAlusel1]     = 1'b1;
                    w_ctrl[CAlusel2]     = !w_is_rr;
                    if (w_is_rr) begin
                        w_ctrl[CAlufunc +: 4] = w_rr_func[3:0];
                    end else if (w_is_ri && (w_op6 != 6'h1A)) begin
                        w_ctrl[CAlufunc +: 4] = w_ri_func[3:0];
                    end
                end
            end
            StMem: begin
                if (w_is_ld) begin
                    w_ctrl[CReaddmem] = 1'b1;
                    w_ctrl[CLdlmd]    = io_bus.dmem_ready;
                end
                if (w_is_st) begin
                    w_ctrl[CWritedmem] = 1'b1;
                end
            end
            StWb: begin
                w_ctrl[CLdpc] = 1'b1;
                if (w_is_rr) begin
                    w_ctrl[CRegwrite] = 1'b1;
                end else if (w_is_ri) begin
                    w_ctrl[CRegwrite] = 1'b1;
                    w_ctrl[CSeldest]  = 1'b1;
                end else if (w_is_ld) begin
                    w_ctrl[CRegwrite] = 1'b1;
                    w_ctrl[CSeldest]  = 1'b1;
                    w_ctrl[CSelwb]    = 1'b1;
                end else if (w_is_br) begin
                    w_ctrl[CBranch] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Reset overrides the decode so nothing fires while the state sits in IF
    assign io_bus.ctrl    = reset ? 24'd0 : w_ctrl;
    assign io_bus.state_o = r_state;
    assign io_bus.halted  = r_halted;
    assign io_bus.error   = r_error;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with hand-computed control words.
module tb_multicycle_ctrl;
    localparam logic [31:0] IAdd   = 32'h0000_0001;
    localparam logic [31:0] IRr10  = 32'h0000_000A;
    localparam logic [31:0] IRr11  = 32'h0000_000B;
    localparam logic [31:0] ISubi  = 32'h4800_0000; // op6 0x12
    localparam logic [31:0] IMove  = 32'h6800_0000; // op6 0x1A
    localparam logic [31:0] ILd    = 32'h8400_0000; // op6 0x21
    localparam logic [31:0] ISt    = 32'h8800_0000; // op6 0x22
    localparam logic [31:0] IBz    = 32'hCC00_0000; // op6 0x33
    localparam logic [31:0] IBad   = 32'hFC00_0000; // op6 0x3F
    localparam logic [31:0] IHalt  = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.IW(32)) bus ();

    multicycle_ctrl #(
        .IW        (32),
        .HALT_WORD (32'hFFFF_FFFF),
        .TIMEOUT   (16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_sc(input string tag, input logic [2:0] st, input logic [23:0] c);
        check({tag, ".state"}, 32'(bus.state_o), 32'(st));
        check({tag, ".ctrl"}, 32'(bus.ctrl), 32'(c));
    endtask

    task automatic apply_reset(input string tag);
        step();
        reset = 1'b1;
        #1;
        expect_sc(tag, 3'd0, 24'h000000);
        check({tag, ".halted"}, 32'(bus.halted), 32'd0);
        check({tag, ".error"}, 32'(bus.error), 32'd0);
        step();
        reset = 1'b0;
    endtask

    // Runs an instruction without memory phase starting from IF
    task automatic run_alu(input string tag, input logic [31:0] ins,
                           input logic [23:0] ex_c, input logic [23:0] wb_c);
        bus.irout = ins;
        step();
        expect_sc({tag, ".id"}, 3'd1, 24'h1C0000);
        step();
        expect_sc({tag, ".ex"}, 3'd2, ex_c);
        step();
        expect_sc({tag, ".wb"}, 3'd4, wb_c);
        step();
        expect_sc({tag, ".if"}, 3'd0, 24'hE00000);
    endtask

    initial begin
        reset          = 1'b1;
        bus.irout      = IAdd;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b1;
        #3;
        expect_sc("rst0", 3'd0, 24'h000000);
        check("rst0.halted", 32'(bus.halted), 32'd0);
        check("rst0.error", 32'(bus.error), 32'd0);
        apply_reset("rst1");
        #1;
        expect_sc("add.if", 3'd0, 24'hE00000);

        run_alu("add", IAdd, 24'h03B000, 24'h000041);
        run_alu("rr10", IRr10, 24'h03B900, 24'h000041);
        run_alu("subi", ISubi, 24'h03F200, 24'h0000C1);
        run_alu("move", IMove, 24'h03F000, 24'h0000C1);
        run_alu("bz", IBz, 24'h027A00, 24'h000003);

        // LD with data memory not ready for 3 cycles
        bus.irout      = ILd;
        bus.dmem_ready = 1'b0;
        step();
        expect_sc("ld.id", 3'd1, 24'h1C0000);
        step();
        expect_sc("ld.ex", 3'd2, 24'h03F000);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) begin
                bus.dmem_ready = 1'b1;
                #1;
                expect_sc("ld.mem_rdy", 3'd3, 24'h000018);
            end else begin
                expect_sc("ld.mem_wait", 3'd3, 24'h000010);
            end
        end
        step();
        expect_sc("ld.wb", 3'd4, 24'h0000C5);
        step();
        expect_sc("ld.if", 3'd0, 24'hE00000);

        // ST aborted by reset while the access is pending
        bus.irout      = ISt;
        bus.dmem_ready = 1'b0;
        step();
        step();
        expect_sc("st.ex", 3'd2, 24'h03F000);
        step();
        expect_sc("st.mem", 3'd3, 24'h000020);
        step();
        reset = 1'b1;
        #1;
        expect_sc("st.abort", 3'd0, 24'h000000);
        step();
        reset          = 1'b0;
        bus.dmem_ready = 1'b1;
        #1;
        expect_sc("st.resume", 3'd0, 24'hE00000);

        // Halt is sticky with ctrl quiet
        bus.irout = IHalt;
        step();
        expect_sc("hlt.id", 3'd1, 24'h1C0000);
        for (int i = 0; i < 21; i++) begin
            step();
            expect_sc("hlt.hold", 3'd5, 24'h000000);
            check("hlt.halted", 32'(bus.halted), 32'd1);
        end
        apply_reset("hlt.rst");
        #1;
        expect_sc("hlt.after", 3'd0, 24'hE00000);

        // Instruction memory never ready -> ERR after 16 cycles
        bus.irout      = IAdd;
        bus.imem_ready = 1'b0;
        #1;
        expect_sc("to.if", 3'd0, 24'h800000);
        for (int i = 0; i < 15; i++) begin
            step();
            check("to.wait", 32'(bus.state_o), 32'd0);
        end
        step();
        expect_sc("to.err", 3'd6, 24'h000000);
        check("to.error", 32'(bus.error), 32'd1);
        step();
        check("to.sticky", 32'(bus.state_o), 32'd6);
        apply_reset("to.rst");

        // Ready arriving on the last allowed cycle wins
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
        end
        check("race.if", 32'(bus.state_o), 32'd0);
        bus.imem_ready = 1'b1;
        step();
        check("race.id", 32'(bus.state_o), 32'd1);
        check("race.error", 32'(bus.error), 32'd0);
        apply_reset("race.rst");

        // Illegal opcodes trap from ID
        bus.irout = IBad;
        step();
        step();
        expect_sc("bad.err", 3'd6, 24'h000000);
        check("bad.error", 32'(bus.error), 32'd1);
        check("bad.halted", 32'(bus.halted), 32'd0);
        apply_reset("bad.rst");
        bus.irout = IRr11;
        step();
        step();
        check("rr11.err", 32'(bus.state_o), 32'd6);
        apply_reset("rr11.rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
